regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the 8x8 two-read register file.
- Generic data width and depth, NUM_RD combinational read ports, one write port.
- Multi-bit condition-flag register with per-bit write mask; optional hardwired-zero register 0.
- Hardware clear sequencer sweeps the array to zero after reset or on request, so the array can map to RAM without a reset network.
- Sits between decode (read addresses) and writeback (write port, flag updates) in the datapath.

Parameters:
- DATA_W, 8: register width in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of independent read ports, 1..4.
- FLAG_W, 1: condition-flag register width.
- ZERO_REG, 0: 1 = entry 0 reads as zero and ignores writes.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- clear_i  in  1  request a full array clear sweep.
- ready_o  out  1  high when the array is usable (not sweeping).
- write_i  in  1  register write enable.
- write_addr_i  in  ADDR_W  write address.
- write_data_i  in  DATA_W  write data.
- flag_we_i  in  FLAG_W  per-bit flag write mask.
- flag_data_i  in  FLAG_W  flag write data.
- flag_data_o  out  FLAG_W  current flags.
- rd_addr_i  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data_o  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].

Behaviour:
- FSM states: CLEAR, READY.
- Reset (rst_n_i=0 at a clock edge):
  - state goes to CLEAR and sweep pointer to 0.
  - flags go to 0 and ready_o to 0.
  - Array contents are not reset directly.
- CLEAR:
  - Each cycle writes 0 to entry[ptr], then increments ptr.
  - After writing entry DEPTH-1, the next state is READY; the sweep takes exactly DEPTH cycles.
  - ready_o rises on the cycle after the last entry is written.
- In CLEAR:
  - write_i and flag_we_i are ignored (dropped, not queued).
  - clear_i has no effect; the sweep is not restarted.
  - All rd_data_o ports read 0; flag_data_o holds 0 after reset.
- READY:
  - write_i=1 writes write_data_i to entry[write_addr_i] at the clock edge.
  - Flag bit i is updated with flag_data_i[i] when flag_we_i[i]=1; other bits hold.
- clear_i=1 in READY:
  - Any write on the same cycle still completes.
  - Next state is CLEAR with ptr=0, so that write is then erased.
  - Flags are NOT cleared by clear_i.
- Reads are combinational from the array: rd_data port k = entry[rd_addr port k].
  - Any number of ports may address the same entry.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 in all states.
- Reset asserted mid-sweep restarts the sweep at ptr=0.
- Same-cycle read and write of the same address: the read returns the old value (see Optional Feature).
- No X on any output after the first reset edge.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined (write-through):
  - In READY with write_i=1, any read port whose address equals write_addr_i returns write_data_i combinationally in the same cycle.
  - This excludes address 0 when ZERO_REG=1.
  - flag_data_o bit i shows flag_data_i[i] when flag_we_i[i]=1.
- Undefined: reads and flag_data_o show registered state only; the new value is visible the cycle after the write.

Decomposition:
- Package regfile_mp_pkg holds:
  - state enum {ST_CLEAR, ST_READY};
  - NUM_RD_MAX=4;
  - a function computing DEPTH from ADDR_W.
- Sub-module regfile_mp_clr_seq contains the CLEAR/READY FSM, the sweep pointer, and ready_o.
  - It supplies the clear-write address and enable to the array muxing in the top module.
- Array, read ports, flags, and bypass logic stay in regfile_mp.

Test Plan:
- Reset then idle (DATA_W=8, ADDR_W=3): ready_o low for exactly 8 cycles after rst_n_i deasserts, then high; all rd_data_o=0 and flag_data_o=0.
- Write/read: write 0xA5 to r3, then 0x3C to r7; next cycle read r3 on port 0 and r7 on port 1 -> 0xA5, 0x3C; no other entry changes.
- Dropped write during sweep: write_i=1 addr 2 data 0xFF at sweep cycle 4 -> r2 reads 0x00 once ready.
- Mid-operation clear: in READY write 0x11 to r5 in the same cycle as clear_i=1 -> ready_o low 8 cycles, then r5=0x00; flags unchanged (e.g. 1 stays 1).
- Flag mask (FLAG_W=4): flags=0b1010, flag_we_i=0b0011, flag_data_i=0b0101 -> flags=0b1001.
- ZERO_REG=1: write 0x77 to r0 -> r0 reads 0x00. With REGFILE_MP_BYPASS_EN: write 0x42 to r1 while reading r1 -> 0x42 same cycle. Without it -> old value, 0x42 next cycle.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
//   state_e     : clear-sequencer states
//   NUM_RD_MAX  : upper bound on the number of read ports
//   calc_depth  : entry count for a given address width
package regfile_mp_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR,
        ST_READY
    } state_e;

    localparam int unsigned NUM_RD_MAX = 4;

    function automatic int unsigned calc_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_mp_clr_seq.sv
// Clear sequencer: sweeps every array entry to zero after reset or on request.
// Ports:
//   clk_i      clock
//   rst_n_i    synchronous active-low reset
//   clear_i    request a new sweep (only honoured when ready)
//   ready_o    high when the array is usable
//   clr_we_o   array write enable for the sweep
//   clr_addr_o entry being cleared this cycle
module regfile_mp_clr_seq
    import regfile_mp_pkg::*;
#(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    output logic              ready_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_CLEAR: begin
                // Pointer wraps back to 0 as the last entry is written.
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready_o    = (state_q == ST_READY);
        clr_we_o   = (state_q == ST_CLEAR);
        clr_addr_o = ptr_q;
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD combinational read ports, one write port,
// masked condition-flag register, optional hardwired-zero entry 0, and a
// clear sequencer so the array itself needs no reset.
// Optional feature: define REGFILE_MP_BYPASS_EN for write-through reads/flags.
// Ports:
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   clear_i / ready_o           sweep request / array usable
//   write_i, write_addr_i,
//   write_data_i                register write port
//   flag_we_i, flag_data_i      per-bit masked flag update
//   flag_data_o                 current flags
//   rd_addr_i / rd_data_o       packed read addresses / data, port k at slice k
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned FLAG_W   = 1,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clear_i,
    output logic                     ready_o,
    input  logic                     write_i,
    input  logic [ADDR_W-1:0]        write_addr_i,
    input  logic [DATA_W-1:0]        write_data_i,
    input  logic [FLAG_W-1:0]        flag_we_i,
    input  logic [FLAG_W-1:0]        flag_data_i,
    output logic [FLAG_W-1:0]        flag_data_o,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o
);

    localparam int unsigned DEPTH  = calc_depth(ADDR_W);
    localparam bit          ZeroEn = (ZERO_REG != 0);

    logic              ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    regfile_mp_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clear_i    (clear_i),
        .ready_o    (ready),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign ready_o = ready;

    // Array write port: sweep has priority; user writes only land when ready.
    logic              user_we;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;

    always_comb begin
        user_we = write_i && ready && !(ZeroEn && (write_addr_i == '0));
        arr_we  = clr_we || user_we;
        if (clr_we) begin
            arr_addr  = clr_addr;
            arr_wdata = '0;
        end else begin
            arr_addr  = write_addr_i;
            arr_wdata = write_data_i;
        end
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (arr_we) begin
            mem_q[arr_addr] <= arr_wdata;
        end
    end

    // Flags: reset to 0, kept across clear_i, updates dropped while sweeping.
    logic [FLAG_W-1:0] flag_q, flag_d;

    always_comb begin
        flag_d = (flag_q & ~flag_we_i) | (flag_data_i & flag_we_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            flag_q <= '0;
        end else if (ready) begin
            flag_q <= flag_d;
        end
    end

`ifdef REGFILE_MP_BYPASS_EN
    assign flag_data_o = ready ? flag_d : flag_q;
`else
    assign flag_data_o = flag_q;
`endif

    for (genvar k = 0; k < NUM_RD; k++) begin : gen_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem_q[addr];
            // Reads during a sweep show 0 so stale contents never leak out.
            if (!ready || (ZeroEn && (addr == '0))) begin
                data = '0;
`ifdef REGFILE_MP_BYPASS_EN
            end else if (user_we && (addr == write_addr_i)) begin
                data = write_data_i;
`endif
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 2;
    localparam int FW = 4;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clear;
    logic           wr;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic [FW-1:0]  fwe;
    logic [FW-1:0]  fdata;
    logic [NR*AW-1:0] raddr;

    logic           ready0, ready1;
    logic [FW-1:0]  flags0, flags1;
    logic [NR*DW-1:0] rdata0, rdata1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .FLAG_W   (FW),
        .ZERO_REG (0)
    ) u_dut0 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .clear_i      (clear),
        .ready_o      (ready0),
        .write_i      (wr),
        .write_addr_i (waddr),
        .write_data_i (wdata),
        .flag_we_i    (fwe),
        .flag_data_i  (fdata),
        .flag_data_o  (flags0),
        .rd_addr_i    (raddr),
        .rd_data_o    (rdata0)
    );

    regfile_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .FLAG_W   (FW),
        .ZERO_REG (1)
    ) u_dut1 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .clear_i      (clear),
        .ready_o      (ready1),
        .write_i      (wr),
        .write_addr_i (waddr),
        .write_data_i (wdata),
        .flag_we_i    (fwe),
        .flag_data_i  (fdata),
        .flag_data_o  (flags1),
        .rd_addr_i    (raddr),
        .rd_data_o    (rdata1)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [FW-1:0] fwe;
        logic [FW-1:0] fdata;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] e0;   // dut0 port 0
        logic [DW-1:0] e1;   // dut0 port 1
        logic [DW-1:0] ez0;  // dut1 (zero-reg) port 0
        logic [FW-1:0] ef;   // flags
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mk(logic w, logic [AW-1:0] wa, logic [DW-1:0] wd,
                                logic [FW-1:0] fw, logic [FW-1:0] fd,
                                logic [AW-1:0] a0, logic [AW-1:0] a1,
                                logic [DW-1:0] x0, logic [DW-1:0] x1,
                                logic [DW-1:0] xz, logic [FW-1:0] xf);
        vec_t v;
        v.wr = w; v.waddr = wa; v.wdata = wd; v.fwe = fw; v.fdata = fd;
        v.ra0 = a0; v.ra1 = a1; v.e0 = x0; v.e1 = x1; v.ez0 = xz; v.ef = xf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [FW-1:0] fw, input logic [FW-1:0] fd, input logic clr,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        wr = w; waddr = wa; wdata = wd; fwe = fw; fdata = fd; clear = clr;
        raddr = {a1, a0};
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts the sweep: ready low for exactly 8 cycles, reads 0 throughout.
    task automatic sweep_check(input string tag, input int drop_cycle);
        for (int c = 0; c < 8; c++) begin
            if (c == drop_cycle) begin
                // Writes, flag updates and clear requests must all be ignored.
                drive(1'b1, 3'd2, 8'hFF, 4'hF, 4'h6, 1'b1, 3'd2, 3'd5);
            end else begin
                idle();
            end
            #1;
            chk({tag, "_ready_low"}, {31'd0, ready0}, 32'd0);
            if (c == drop_cycle) begin
                chk({tag, "_rd_zero"}, {16'd0, rdata0}, 32'd0);
            end
            tick();
        end
        idle();
        #1;
        chk({tag, "_ready_high"}, {30'd0, ready1, ready0}, 32'd3);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        #1;
        chk("rst_ready", {31'd0, ready0}, 32'd0);
        chk("rst_flags", {28'd0, flags0}, 32'd0);

        // Power-up sweep with a dropped write at sweep cycle 4.
        rst_n = 1'b1;
        sweep_check("init", 4);

        tbl[0] = mk(0, 3'd0, 8'h00, 4'h0, 4'h0, 3'd2, 3'd0, 8'h00, 8'h00, 8'h00, 4'h0);
        tbl[1] = mk(1, 3'd3, 8'hA5, 4'h0, 4'h0, 3'd0, 3'd1, 8'h00, 8'h00, 8'h00, 4'h0);
        tbl[2] = mk(1, 3'd7, 8'h3C, 4'h0, 4'h0, 3'd3, 3'd2, 8'hA5, 8'h00, 8'hA5, 4'h0);
        tbl[3] = mk(0, 3'd0, 8'h00, 4'hF, 4'hA, 3'd3, 3'd7, 8'hA5, 8'h3C, 8'hA5,
                    BYP ? 4'hA : 4'h0);
        tbl[4] = mk(0, 3'd0, 8'h00, 4'h3, 4'h5, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'hA5,
                    BYP ? 4'h9 : 4'hA);
        tbl[5] = mk(0, 3'd0, 8'h00, 4'h0, 4'h0, 3'd4, 3'd6, 8'h00, 8'h00, 8'h00, 4'h9);
        tbl[6] = mk(1, 3'd0, 8'h77, 4'h0, 4'h0, 3'd1, 3'd6, 8'h00, 8'h00, 8'h00, 4'h9);
        tbl[7] = mk(0, 3'd0, 8'h00, 4'h0, 4'h0, 3'd0, 3'd7, 8'h77, 8'h3C, 8'h00, 4'h9);
        tbl[8] = mk(0, 3'd0, 8'h00, 4'h0, 4'h0, 3'd5, 3'd2, 8'h00, 8'h00, 8'h00, 4'h9);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].wr, tbl[i].waddr, tbl[i].wdata, tbl[i].fwe, tbl[i].fdata, 1'b0,
                  tbl[i].ra0, tbl[i].ra1);
            #1;
            chk($sformatf("vec%0d_rd0", i), {24'd0, rdata0[7:0]}, {24'd0, tbl[i].e0});
            chk($sformatf("vec%0d_rd1", i), {24'd0, rdata0[15:8]}, {24'd0, tbl[i].e1});
            chk($sformatf("vec%0d_z_rd0", i), {24'd0, rdata1[7:0]}, {24'd0, tbl[i].ez0});
            chk($sformatf("vec%0d_flags", i), {28'd0, flags0}, {28'd0, tbl[i].ef});
            tick();
        end

        // Same-cycle write/read of r1, and of r0 on both variants.
        drive(1'b1, 3'd1, 8'h42, 4'h0, 4'h0, 1'b0, 3'd1, 3'd1);
        #1;
        chk("byp_r1", {24'd0, rdata0[7:0]}, BYP ? 32'h42 : 32'h00);
        tick();
        drive(1'b1, 3'd0, 8'h99, 4'h0, 4'h0, 1'b0, 3'd1, 3'd0);
        #1;
        chk("r1_next", {24'd0, rdata0[7:0]}, 32'h42);
        chk("byp_r0", {24'd0, rdata0[15:8]}, BYP ? 32'h99 : 32'h77);
        chk("z_byp_r0", {24'd0, rdata1[15:8]}, 32'h00);
        tick();
        idle();
        #1;
        chk("r0_next", {24'd0, rdata0[7:0]}, 32'h99);
        chk("z_r0_next", {24'd0, rdata1[7:0]}, 32'h00);

        // Clear in READY with a same-cycle write to r5: write lands, then is erased.
        drive(1'b1, 3'd5, 8'h11, 4'h0, 4'h0, 1'b1, 3'd5, 3'd3);
        tick();
        sweep_check("clr", 3);
        drive(1'b0, 3'd0, 8'h00, 4'h0, 4'h0, 1'b0, 3'd5, 3'd3);
        #1;
        chk("clr_r5", {24'd0, rdata0[7:0]}, 32'h00);
        chk("clr_r3", {24'd0, rdata0[15:8]}, 32'h00);
        chk("clr_flags_kept", {28'd0, flags0}, 32'h9);

        // Reset during a sweep restarts it from entry 0 and zeroes flags.
        drive(1'b0, 3'd0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd0, 3'd0);
        tick();
        idle();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sweep_check("rst_mid", 6);
        chk("rst_mid_flags", {28'd0, flags0}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
